// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: port indices and the
// per-port response state encoding.
package mem_arb_pkg;

    localparam int PORT_LSU = 0;
    localparam int PORT_IF  = 1;

    localparam logic [0:0] RSP_IDLE  = 1'b0;
    localparam logic [0:0] RSP_VALID = 1'b1;

    // A word access must start on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. A lone requester is always granted; on a tie
// the port that did not win the last accepted grant wins. The history only
// moves on an accept, so a stalled tie cannot flip the winner.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // One-hot grant from the valids and the last winner.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner of each accepted grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant[1];
        end
    end

    // Reset to "port 1 won last" so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one big-endian word memory between the load/store unit (port 0)
// and instruction fetch (port 1). One access per cycle, round-robin on ties,
// read data returned one cycle after the accept. Misaligned requests are
// accepted but never touch memory and respond with err set.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int addresswidth = 28,
    parameter int datawidth    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [addresswidth-1:0] req0_address,
    input  logic                    req0_write,
    input  logic [datawidth-1:0]    req0_data,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [addresswidth-1:0] req1_address,
    output logic                    resp0_valid,
    output logic [datawidth-1:0]    resp0_data,
    output logic                    resp0_err,
    output logic                    resp1_valid,
    output logic [datawidth-1:0]    resp1_data,
    output logic                    resp1_err,
    output logic [addresswidth-1:0] mem_address,
    output logic                    mem_writeEnable,
    output logic [datawidth-1:0]    mem_dataIn,
    input  logic [datawidth-1:0]    mem_dataOut
);

    logic [1:0]                    valid_m;
    logic [1:0]                    grant;
    logic                          accept;
    logic                          misaligned;

    logic [1:0]                    rsp_state_q, rsp_state_d;
    logic [1:0][datawidth-1:0]     rsp_data_q, rsp_data_d;
    logic [1:0]                    rsp_err_q, rsp_err_d;

    // Nothing is granted while reset is held.
    assign valid_m = reset ? 2'b00 : {req1_valid, req0_valid};

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid_m),
        .accept (accept),
        .grant  (grant)
    );

    assign accept     = |grant;
    assign req0_ready = grant[PORT_LSU];
    assign req1_ready = grant[PORT_IF];

    // Memory drive: granted port's address, port 0 store data, all zero idle.
    always_comb begin
        mem_address     = '0;
        mem_dataIn      = '0;
        mem_writeEnable = 1'b0;
        if (grant[PORT_LSU]) begin
            mem_address = req0_address;
            mem_dataIn  = req0_data;
        end else if (grant[PORT_IF]) begin
            mem_address = req1_address;
        end
        misaligned      = is_misaligned(mem_address[1:0]);
        mem_writeEnable = grant[PORT_LSU] & req0_write & ~misaligned;
    end

    // Next response per port: load the read word on an accept, zero for
    // stores and misaligned accesses, otherwise fall back to idle.
    always_comb begin
        rsp_state_d = {RSP_IDLE, RSP_IDLE};
        rsp_data_d  = '0;
        rsp_err_d   = 2'b00;
        for (int p = 0; p < 2; p++) begin
            if (grant[p]) begin
                rsp_state_d[p] = RSP_VALID;
                rsp_err_d[p]   = misaligned;
                if (!(misaligned || (p == PORT_LSU && req0_write))) begin
                    rsp_data_d[p] = mem_dataOut;
                end
            end
        end
    end

    // Response registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_state_q <= {RSP_IDLE, RSP_IDLE};
            rsp_data_q  <= '0;
            rsp_err_q   <= 2'b00;
        end else begin
            rsp_state_q <= rsp_state_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // A response pending when reset arrives is suppressed immediately.
    assign resp0_valid = (rsp_state_q[PORT_LSU] == RSP_VALID) && !reset;
    assign resp1_valid = (rsp_state_q[PORT_IF] == RSP_VALID) && !reset;
    assign resp0_data  = reset ? '0 : rsp_data_q[PORT_LSU];
    assign resp1_data  = reset ? '0 : rsp_data_q[PORT_IF];
    assign resp0_err   = rsp_err_q[PORT_LSU] & ~reset;
    assign resp1_err   = rsp_err_q[PORT_IF] & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a byte-wide big-endian memory model attached
// to the memory port, directed scenarios followed by random traffic, all
// checked against a word-level reference of the arbitration rules.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_write;
    logic [27:0] req0_address;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [27:0] req1_address;
    logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
    logic [31:0] resp0_data, resp1_data;
    logic [27:0] mem_address;
    logic        mem_writeEnable;
    logic [31:0] mem_dataIn, mem_dataOut;

    always #5 clk = ~clk;

    mem_port_arbiter #(.addresswidth(28), .datawidth(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_ready      (req0_ready),
        .req0_address    (req0_address),
        .req0_write      (req0_write),
        .req0_data       (req0_data),
        .req1_valid      (req1_valid),
        .req1_ready      (req1_ready),
        .req1_address    (req1_address),
        .resp0_valid     (resp0_valid),
        .resp0_data      (resp0_data),
        .resp0_err       (resp0_err),
        .resp1_valid     (resp1_valid),
        .resp1_data      (resp1_data),
        .resp1_err       (resp1_err),
        .mem_address     (mem_address),
        .mem_writeEnable (mem_writeEnable),
        .mem_dataIn      (mem_dataIn),
        .mem_dataOut     (mem_dataOut)
    );

    // Attached memory: 256 bytes, big-endian, combinational read.
    logic [7:0] mem [256];
    logic       mem_init;
    logic [7:0] ma;
    assign ma = mem_address[7:0];
    assign mem_dataOut = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_writeEnable) begin
            mem[ma]        <= mem_dataIn[31:24];
            mem[ma + 8'd1] <= mem_dataIn[23:16];
            mem[ma + 8'd2] <= mem_dataIn[15:8];
            mem[ma + 8'd3] <= mem_dataIn[7:0];
        end
    end

    // Reference state: word contents, last tie winner, pending responses.
    logic [31:0] ref_mem [64];
    int          last_win;
    bit          pv0, pv1, pe0, pe1;
    logic [31:0] pd0, pd1;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the reference, advance.
    task automatic step(input bit v0, input logic [27:0] a0, input bit w0,
                        input logic [31:0] d0, input bit v1, input logic [27:0] a1,
                        input bit rst, output bit acc0, output bit acc1);
        bit          g0, g1, mis;
        logic [27:0] ga;
        reset = rst; req0_valid = v0; req0_address = a0; req0_write = w0;
        req0_data = d0; req1_valid = v1; req1_address = a1;
        #1;
        g0 = 0; g1 = 0;
        if (!rst) begin
            if (v0 && v1) begin
                if (last_win == 1) g0 = 1; else g1 = 1;
            end else begin
                g0 = v0; g1 = v1;
            end
        end
        ga  = g0 ? a0 : (g1 ? a1 : 28'd0);
        mis = (ga % 4) != 0;
        chk("ready0", {31'd0, req0_ready}, {31'd0, g0});
        chk("ready1", {31'd0, req1_ready}, {31'd0, g1});
        chk("mem_we", {31'd0, mem_writeEnable}, {31'd0, g0 && w0 && !mis});
        chk("mem_addr", {4'd0, mem_address}, {4'd0, ga});
        chk("mem_din", mem_dataIn, g0 ? d0 : 32'd0);
        chk("resp0_valid", {31'd0, resp0_valid}, {31'd0, pv0 && !rst});
        chk("resp0_data", resp0_data, rst ? 32'd0 : pd0);
        chk("resp0_err", {31'd0, resp0_err}, {31'd0, pe0 && !rst});
        chk("resp1_valid", {31'd0, resp1_valid}, {31'd0, pv1 && !rst});
        chk("resp1_data", resp1_data, rst ? 32'd0 : pd1);
        chk("resp1_err", {31'd0, resp1_err}, {31'd0, pe1 && !rst});
        pv0 = 0; pv1 = 0; pe0 = 0; pe1 = 0; pd0 = 0; pd1 = 0;
        if (g0) begin
            pv0 = 1; pe0 = mis;
            pd0 = (w0 || mis) ? 32'd0 : ref_mem[ga[7:2]];
            if (w0 && !mis) ref_mem[ga[7:2]] = d0;
            last_win = 0;
        end
        if (g1) begin
            pv1 = 1; pe1 = mis;
            pd1 = mis ? 32'd0 : ref_mem[ga[7:2]];
            last_win = 1;
        end
        if (rst) last_win = 1;
        acc0 = g0; acc1 = g1;
        @(negedge clk);
    endtask

    initial begin
        bit          k0, k1;
        bit          h0, h1, rw;
        logic [27:0] ra0, ra1;
        logic [31:0] rd;
        bit          rs;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        last_win = 1;
        pv0 = 0; pv1 = 0; pe0 = 0; pe1 = 0; pd0 = 0; pd1 = 0;
        mem_init = 1'b1;
        reset = 1'b1; req0_valid = 0; req0_address = 0; req0_write = 0;
        req0_data = 0; req1_valid = 0; req1_address = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0, 1, k0, k1);
        mem_init = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1, k0, k1);

        // Store then load the same word, then idle to see the load data.
        step(1, 28'h10, 1, 32'hDEADBEEF, 0, 0, 0, k0, k1);
        step(1, 28'h10, 0, 32'h0, 0, 0, 0, k0, k1);
        step(0, 0, 0, 0, 0, 0, 0, k0, k1);

        // Tie from reset: grants alternate starting with port 0.
        step(0, 0, 0, 0, 0, 0, 1, k0, k1);
        for (int i = 0; i < 4; i++) step(1, 28'h10, 0, 0, 1, 28'h20, 0, k0, k1);
        step(0, 0, 0, 0, 0, 0, 0, k0, k1);

        // Misaligned store leaves the word intact.
        step(1, 28'h13, 1, 32'h12345678, 0, 0, 0, k0, k1);
        step(1, 28'h10, 0, 0, 0, 0, 0, k0, k1);
        step(0, 0, 0, 0, 0, 0, 0, k0, k1);

        // Store on port 0 visible to a fetch on the very next cycle.
        step(1, 28'h40, 1, 32'hA5A50F0F, 0, 0, 0, k0, k1);
        step(0, 0, 0, 0, 1, 28'h40, 0, k0, k1);
        step(0, 0, 0, 0, 0, 0, 0, k0, k1);

        // Reset right after a fetch accept drops it; then port 0 wins the tie.
        step(0, 0, 0, 0, 1, 28'h20, 0, k0, k1);
        step(0, 0, 0, 0, 1, 28'h20, 1, k0, k1);
        step(1, 28'h40, 0, 0, 1, 28'h20, 0, k0, k1);
        step(0, 0, 0, 0, 0, 0, 0, k0, k1);

        // Random traffic; requesters hold their request until accepted.
        h0 = 0; h1 = 0; ra0 = 0; ra1 = 0; rw = 0; rd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!h0 && $urandom_range(0, 2) != 0) begin
                h0  = 1;
                ra0 = 28'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) ra0[1:0] = 2'b00;
                rw  = $urandom_range(0, 1) == 1;
                rd  = $urandom;
            end
            if (!h1 && $urandom_range(0, 2) != 0) begin
                h1  = 1;
                ra1 = 28'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) ra1[1:0] = 2'b00;
            end
            rs = $urandom_range(0, 39) == 0;
            step(h0, ra0, rw, rd, h1, ra1, rs, k0, k1);
            if (k0) h0 = 0;
            if (k1) h1 = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, k0, k1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
